// File: rtl/pc_pkg.sv
// Shared encodings for the fetch-stage PC generator: redirect types, FSM states
// and PC increment sizes.
package pc_pkg;

    typedef enum logic [1:0] {
        REDIR_BR   = 2'b00,
        REDIR_JAL  = 2'b01,
        REDIR_JALR = 2'b10,
        REDIR_TRAP = 2'b11
    } redir_type_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } pc_state_e;

    localparam int unsigned INC_RVC = 2;
    localparam int unsigned INC_STD = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target: computes the target, whether the redirect is
// effective, and whether the raw target is misaligned. Honours PC_GEN_RVC_EN.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic            valid_i,
    input  logic [1:0]      type_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic            taken_i,
    output logic            eff_o,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] raw;

    always_comb begin
        raw = TRAP_VECTOR;
        case (redir_type_e'(type_i))
            REDIR_BR, REDIR_JAL: raw = pc_i + imm_i;
            REDIR_JALR: begin
                raw    = rs1_i + imm_i;
                raw[0] = 1'b0;
            end
            REDIR_TRAP: raw = TRAP_VECTOR;
        endcase
    end

    assign eff_o = valid_i && ((redir_type_e'(type_i) != REDIR_BR) || taken_i);

`ifdef PC_GEN_RVC_EN
    assign misalign_o = raw[0];
`else
    assign misalign_o = |raw[1:0];
`endif

    // Misaligned targets are diverted to the trap handler.
    assign target_o = misalign_o ? TRAP_VECTOR : raw;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter with req/gnt handshake, redirect handling and a
// pending-redirect buffer. Define PC_GEN_RVC_EN for compressed-instruction support.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redir_valid_i,
    input  logic [1:0]      redir_type_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] redir_pc_i,
    input  logic [XLEN-1:0] redir_imm_i,
    input  logic [XLEN-1:0] redir_rs1_i,
    input  logic            if_gnt_i,
`ifdef PC_GEN_RVC_EN
    input  logic            is_rvc_i,
`endif
    output logic            if_req_o,
    output logic [XLEN-1:0] if_addr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            kill_o,
    output logic            misalign_o
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            outst_q, outst_d;
    logic            misalign_q, misalign_d;

    logic            redir_eff;
    logic [XLEN-1:0] redir_tgt;
    logic            redir_mis;
    logic [XLEN-1:0] inc;
    logic            req;
    logic            kill;

    pc_target_calc #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_target_calc (
        .valid_i    (redir_valid_i),
        .type_i     (redir_type_i),
        .pc_i       (redir_pc_i),
        .imm_i      (redir_imm_i),
        .rs1_i      (redir_rs1_i),
        .taken_i    (br_taken_i),
        .eff_o      (redir_eff),
        .target_o   (redir_tgt),
        .misalign_o (redir_mis)
    );

`ifdef PC_GEN_RVC_EN
    assign inc = is_rvc_i ? XLEN'(INC_RVC) : XLEN'(INC_STD);
`else
    assign inc = XLEN'(INC_STD);
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        outst_d    = 1'b0;
        misalign_d = 1'b0;
        req        = 1'b0;
        kill       = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                // An ungranted request from last cycle must be held regardless of stall.
                req        = !stall_i || outst_q;
                misalign_d = redir_eff && redir_mis;
                if (redir_eff) begin
                    if (req && !if_gnt_i) begin
                        pend_d  = redir_tgt;
                        state_d = ST_HOLD;
                    end else begin
                        pc_d = redir_tgt;
                        kill = req && if_gnt_i;
                    end
                end else if (req) begin
                    if (if_gnt_i) pc_d = pc_q + inc;
                    else          outst_d = 1'b1;
                end
            end
            ST_HOLD: begin
                req        = 1'b1;
                misalign_d = redir_eff && redir_mis;
                if (if_gnt_i) begin
                    pc_d    = redir_eff ? redir_tgt : pend_q;
                    kill    = 1'b1;
                    state_d = ST_FETCH;
                end else if (redir_eff) begin
                    pend_d = redir_tgt;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            pend_q     <= '0;
            outst_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            outst_q    <= outst_d;
            misalign_q <= misalign_d;
        end
    end

    assign if_req_o   = req;
    assign kill_o     = kill;
    assign pc_o       = pc_q;
    assign if_addr_o  = pc_q;
    assign pc_plus4_o = pc_q + XLEN'(INC_STD);
    assign misalign_o = misalign_q;

endmodule
